// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on magnitudes, one step per cycle.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            InValid,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Flush,
  output logic            Stall,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   prod_q;
  logic [XLEN-1:0] opnd_q;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] result_q;

  logic            req;
  logic            a_signed, b_signed, a_neg, b_neg, neg_start;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;
  logic            last;

  assign req = InValid & (ALUOp == 2'b10) & (Funct7 == 7'b0000001) & ~Flush;

  // Operand signedness and magnitudes at issue
  assign a_signed  = (Funct3 == 3'b001) | (Funct3 == 3'b010) | (Funct3 == 3'b100) | (Funct3 == 3'b110);
  assign b_signed  = (Funct3 == 3'b001) | (Funct3 == 3'b100) | (Funct3 == 3'b110);
  assign a_neg     = a_signed & SrcA[XLEN-1];
  assign b_neg     = b_signed & SrcB[XLEN-1];
  assign a_mag     = a_neg ? -SrcA : SrcA;
  assign b_mag     = b_neg ? -SrcB : SrcB;
  assign neg_start = (Funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);

  // Divide-by-zero and signed overflow resolve without iterating
  assign div_zero = (SrcB == '0);
  assign div_ovf  = ~Funct3[0] & (SrcA == {1'b1, {(XLEN-1){1'b0}}}) & (SrcB == '1);
  assign fast     = Funct3[2] & (div_zero | div_ovf);
  assign fast_res = div_zero ? (Funct3[1] ? SrcA : '1) : (Funct3[1] ? '0 : SrcA);

  // One radix-2 step; hi half is partial product / partial remainder
  logic [XLEN:0]   mul_sum, rem_sh, rem_diff;
  logic            rem_ge;
  logic [PW-1:0]   mul_step, div_step, step, prod_corr;
  logic [XLEN-1:0] q_corr, r_corr, final_res;

  always_comb begin
    mul_sum   = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_step  = {mul_sum, prod_q[XLEN-1:1]};
    rem_sh    = {prod_q[PW-1:XLEN], prod_q[XLEN-1]};
    rem_diff  = rem_sh - {1'b0, opnd_q};
    rem_ge    = ~rem_diff[XLEN];
    div_step  = {(rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), prod_q[XLEN-2:0], rem_ge};
    step      = op_q[2] ? div_step : mul_step;
    prod_corr = neg_q ? -step : step;
    q_corr    = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    r_corr    = neg_q ? -step[PW-1:XLEN] : step[PW-1:XLEN];
    case (op_q)
      3'b000:                 final_res = prod_corr[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_corr[PW-1:XLEN];
      3'b100, 3'b101:         final_res = q_corr;
      default:                final_res = r_corr;
    endcase
  end

  assign last = (count_q == CW'(XLEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = fast ? DONE : BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Flush) state_d = IDLE;
  end

  // Datapath: capture at issue, iterate while busy, publish on the final step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (!Flush) begin
      if (state_q == IDLE && req) begin
        op_q    <= Funct3;
        neg_q   <= neg_start;
        count_q <= '0;
        prod_q  <= {{XLEN{1'b0}}, (Funct3[2] ? a_mag : b_mag)};
        opnd_q  <= Funct3[2] ? b_mag : a_mag;
        if (fast) result_q <= fast_res;
      end else if (state_q == BUSY) begin
        prod_q  <= step;
        count_q <= count_q + CW'(1);
        if (last) result_q <= final_res;
      end
    end
  end

  assign Busy   = (state_q == BUSY);
  assign Done   = (state_q == DONE) & ~Flush;
  assign Stall  = req & ~Done & ~reset;
  assign Result = result_q;

endmodule
